// File: rtl/serial_add.sv
// Bit-serial adder recovering A = C + B (mod 2^W), LSB first, start/busy/done handshake.
// Optional flag outputs (carry, overflow, zero) are built only when SERIAL_ADD_FLAGS_EN is defined.
module serial_add #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] C,
  input  logic [W-1:0] B,
  output logic [W-1:0] A,
  output logic         busy,
  output logic         done,
  output logic         carry,
  output logic         overflow,
  output logic         zero
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  c_sh_q, b_sh_q, res_q, a_q;
  logic [CW-1:0] cnt_q;
  logic          cy_q, busy_q, done_q;

  logic          sum_bit_d, cy_d, last_bit_d;
  logic [W-1:0]  res_d;

`ifdef SERIAL_ADD_FLAGS_EN
  logic carry_q, overflow_q, zero_q;
`endif

  always_comb begin
    sum_bit_d  = c_sh_q[0] ^ b_sh_q[0] ^ cy_q;
    cy_d       = (c_sh_q[0] & b_sh_q[0]) | (c_sh_q[0] & cy_q) | (b_sh_q[0] & cy_q);
    res_d      = {sum_bit_d, res_q[W-1:1]};
    last_bit_d = (cnt_q == CW'(W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            c_sh_q  <= C;
            b_sh_q  <= B;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          c_sh_q <= c_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          cy_q   <= cy_d;
          res_q  <= res_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit_d) begin
            a_q     <= res_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_ADD_FLAGS_EN
            // Operand bit 0 now holds the captured sign bits of C and B
            carry_q    <= cy_d;
            overflow_q <= (c_sh_q[0] == b_sh_q[0]) && (sum_bit_d != c_sh_q[0]);
            zero_q     <= (res_d == '0);
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign A    = a_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SERIAL_ADD_FLAGS_EN
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule
